// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// combinational ALU. Each accepted operation is held in operand registers
// for one execute cycle, and its result is then held in the owner's
// response registers until that owner takes it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       op_ctrl_q, op_ctrl_d;

  logic [WIDTH-1:0] rsp_result_q [2];
  logic             rsp_zero_q   [2];

  logic             grant_sel;
  logic             handshake;
  logic             owner_rsp_ready;

  // Pick the requester to offer: a lone valid wins, a tie goes to the one
  // that was not served last.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant_q;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
  end

  // Ready only in IDLE, only for the chosen requester and only while it is
  // valid; held low while reset is asserted.
  always_comb begin
    req0_ready = ~reset && (state_q == S_IDLE) && req0_valid && !grant_sel;
    req1_ready = ~reset && (state_q == S_IDLE) && req1_valid &&  grant_sel;
  end

  assign handshake       = req0_ready | req1_ready;
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state logic for the IDLE -> EXEC -> RESP cycle and the operand latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_ctrl_d    = op_ctrl_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          owner_d      = req1_ready;
          last_grant_d = req1_ready;
          op_a_d       = req1_ready ? req1_a  : req0_a;
          op_b_d       = req1_ready ? req1_b  : req0_b;
          op_ctrl_d    = req1_ready ? req1_op : req0_op;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and operand state; last_grant resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= 3'b000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_ctrl_q    <= op_ctrl_d;
    end
  end

  // Per-requester response registers, loaded from the ALU during EXEC when
  // that requester owns the transaction and held otherwise.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rsp_result_q[gi] <= '0;
        rsp_zero_q[gi]   <= 1'b0;
      end else if ((state_q == S_EXEC) && (owner_q == 1'(gi))) begin
        rsp_result_q[gi] <= alu_result;
        rsp_zero_q[gi]   <= alu_zero;
      end
    end
  end

  // The ALU only ever sees registered operands, so request inputs that change
  // after the handshake cannot disturb the transaction.
  assign alu_a    = op_a_q;
  assign alu_b    = op_b_q;
  assign alu_ctrl = op_ctrl_q;

  assign rsp0_valid  = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid  = (state_q == S_RESP) &&  owner_q;
  assign rsp0_result = rsp_result_q[0];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp1_zero   = rsp_zero_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a reference ALU on the shared port.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_ctrl;
  logic             alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Reference ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      3'b110: alu_result = alu_a << alu_b[4:0];
      default: alu_result = alu_a >> alu_b[4:0];
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep_exp [8];
  logic        exp_owner;

  initial begin
    sweep_exp[0] = 32'h0000000F; sweep_exp[1] = 32'h00000009;
    sweep_exp[2] = 32'h00000000; sweep_exp[3] = 32'h0000000F;
    sweep_exp[4] = 32'h0000000F; sweep_exp[5] = 32'h00000000;
    sweep_exp[6] = 32'h00000060; sweep_exp[7] = 32'h00000001;

    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = '0;    req1_b = '0;    req1_op = 3'b000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state (valids high: ready must still be low)
    tick(); tick();
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_ctrl",   alu_ctrl, 0);
    chk("rst_alu_a",      alu_a, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_zero",  rsp1_zero, 0);

    // Single request: req0 add 5+7
    tick();
    reset = 1'b0; req1_valid = 1'b0;
    #1;
    $display("txn single req0 add 5+7");
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    tick();                                   // cycle 1: EXEC
    req0_valid = 1'b0; req0_a = 32'hDEAD; req0_op = 3'b111;
    #1;
    chk("single_alu_a", alu_a, 5);
    chk("single_alu_ctrl", alu_ctrl, 0);
    chk("single_rsp0_valid_c1", rsp0_valid, 0);
    tick();                                   // cycle 2: RESP
    rsp0_ready = 1'b1;
    #1;
    chk("single_rsp0_valid_c2", rsp0_valid, 1);
    chk("single_rsp0_result", rsp0_result, 12);
    chk("single_rsp0_zero", rsp0_zero, 0);
    chk("single_rsp1_valid", rsp1_valid, 0);
    tick();
    #1;
    chk("single_back_idle", rsp0_valid, 0);

    // Tie after a fresh reset: grant order 0,1,0,1
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 3'b011;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    exp_owner = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("txn tie round %0d expecting req%0d", i, exp_owner);
      chk("tie_req0_ready", req0_ready, !exp_owner);
      chk("tie_req1_ready", req1_ready, exp_owner);
      tick(); tick();
      #1;
      chk("tie_rsp0_valid", rsp0_valid, !exp_owner);
      chk("tie_rsp1_valid", rsp1_valid, exp_owner);
      if (exp_owner) begin
        chk("tie_rsp1_result", rsp1_result, 32'hFF);
        chk("tie_rsp1_zero", rsp1_zero, 0);
      end else begin
        chk("tie_rsp0_result", rsp0_result, 0);
        chk("tie_rsp0_zero", rsp0_zero, 1);
      end
      tick();
      exp_owner = ~exp_owner;
    end

    // Backpressure on rsp0, req1 waiting
    req1_valid = 1'b0;
    req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'b000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    $display("txn backpressure req0 add 3+4");
    chk("bp_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFFFFFD; req1_b = 32'd1; req1_op = 3'b101;
    #1;
    chk("bp_req1_ready_exec", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp0_result", rsp0_result, 7);
      chk("bp_req1_ready", req1_ready, 0);
      tick();
    end
    rsp1_ready = 1'b1;                        // non-owner ready is ignored
    rsp0_ready = 1'b1;
    #1;
    chk("bp_rsp0_valid_release", rsp0_valid, 1);
    chk("bp_rsp1_valid_release", rsp1_valid, 0);
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("bp_idle_rsp0_valid", rsp0_valid, 0);
    chk("bp_idle_req1_ready", req1_ready, 1);

    // slt pass-through on req1
    $display("txn req1 slt 0xFFFFFFFD,1");
    tick();
    req1_valid = 1'b0;
    #1;
    chk("slt_alu_ctrl", alu_ctrl, 3'b101);
    chk("slt_alu_a", alu_a, 32'hFFFFFFFD);
    tick();
    rsp1_ready = 1'b1;
    #1;
    chk("slt_rsp1_valid", rsp1_valid, 1);
    chk("slt_rsp1_result", rsp1_result, 1);
    chk("slt_rsp1_zero", rsp1_zero, 0);
    chk("slt_rsp0_valid", rsp0_valid, 0);
    tick();
    rsp1_ready = 1'b0;

    // Valid that drops before any edge is dropped without effect
    req0_valid = 1'b1; req0_a = 32'h55;
    #1;
    req0_valid = 1'b0;
    tick();
    #1;
    $display("txn dropped request");
    chk("drop_alu_a", alu_a, 32'hFFFFFFFD);
    chk("drop_rsp0_valid", rsp0_valid, 0);

    // All eight op codes through req0 with a=0xC, b=3
    rsp0_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_a = 32'hC; req0_b = 32'd3; req0_op = 3'(i);
      #1;
      $display("txn sweep op %0d", i);
      chk("sweep_req0_ready", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("sweep_alu_ctrl", alu_ctrl, 32'(i));
      tick();
      #1;
      chk("sweep_rsp0_result", rsp0_result, sweep_exp[i]);
      chk("sweep_rsp0_zero", rsp0_zero, (sweep_exp[i] == 0) ? 1 : 0);
      tick();
    end

    // Reset during EXEC abandons the transaction
    req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'hFF; req0_op = 3'b100;
    tick();
    req0_valid = 1'b0;
    #1;
    $display("txn reset mid-op");
    chk("rmo_alu_ctrl_exec", alu_ctrl, 3'b100);
    reset = 1'b1;
    #1;
    chk("rmo_rsp0_valid", rsp0_valid, 0);
    chk("rmo_rsp1_valid", rsp1_valid, 0);
    chk("rmo_alu_ctrl", alu_ctrl, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rmo_no_rsp0", rsp0_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have, for n in {0,1}, port reqn_valid, input, 1, requester n has an operation pending.
REQ-005 SHALL have, for n in {0,1}, port reqn_ready, output, 1, arbiter accepts requester n this cycle.
REQ-006 SHALL have, for n in {0,1}, ports reqn_a and reqn_b, input, WIDTH, operands.
REQ-007 SHALL have, for n in {0,1}, port reqn_op, input, 3, ALU control code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
REQ-008 SHALL have, for n in {0,1}, port rspn_valid, output, 1, result for requester n is available.
REQ-009 SHALL have, for n in {0,1}, port rspn_ready, input, 1, requester n consumes the result.
REQ-010 SHALL have, for n in {0,1}, ports rspn_result (output, WIDTH) and rspn_zero (output, 1), captured ALU result and zero flag.
REQ-011 SHALL have ports alu_a and alu_b, output, WIDTH, operands to the shared ALU.
REQ-012 SHALL have port alu_ctrl, output, 3, control code to the shared ALU.
REQ-013 SHALL have ports alu_result (input, WIDTH) and alu_zero (input, 1), combinational outputs of the shared ALU.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-015 In IDLE, the arbiter SHALL grant exactly one valid requester: if only one reqn_valid is high, that one; if both are high, the one not equal to last_grant.
REQ-016 reqn_ready SHALL be high only in IDLE, only for the granted requester, and only while its reqn_valid is high; it SHALL be combinational from state, last_grant and the valid inputs.
REQ-017 On a handshake (reqn_valid & reqn_ready), the arbiter SHALL register reqn_a, reqn_b and reqn_op into the operand registers, record owner = n, set last_grant = n, and go to EXEC.
REQ-018 alu_a, alu_b and alu_ctrl SHALL always be driven from the operand registers, never directly from request inputs.
REQ-019 In EXEC, the arbiter SHALL capture alu_result and alu_zero into the owner's response registers and go to RESP after one cycle.
REQ-020 In RESP, rsp[owner]_valid SHALL be high and the result and zero outputs SHALL be held stable until rsp[owner]_ready is high, then return to IDLE on that edge.
REQ-021 Latency from request handshake edge to rspn_valid high SHALL be 2 cycles; minimum issue interval SHALL be 3 cycles.
REQ-022 rspn_ready SHALL be ignored when n is not the owner or the state is not RESP; rspn_valid of the non-owner SHALL stay low.
REQ-023 A request whose valid drops before its handshake SHALL be dropped with no state change; inputs after the handshake SHALL not affect the transaction.
REQ-024 The block SHALL pass all 8 op codes unmodified; it SHALL not interpret results or flags.

Reset
REQ-025 While reset is high: state = IDLE, last_grant = 1 (req0 wins the first tie), owner = 0, operand registers = 0, alu_ctrl = 000, all rspn_valid = 0, all rspn_result = 0, all rspn_zero = 0, all reqn_ready = 0.
REQ-026 Reset asserted in EXEC or RESP SHALL abandon the transaction with no response delivered; operation resumes in IDLE after reset deasserts.

Verification
REQ-027 Single request: req0 add, a=5, b=7, at cycle 0 -> req0_ready=1 at cycle 0; rsp0_valid=1 at cycle 2 with rsp0_result=12 and rsp0_zero=0.
REQ-028 Tie after reset: req0 sub with a=9, b=9, and req1 or with a=0xF0, b=0x0F, both held -> req0 is served first (result 0, zero=1), then req1 (result 0xFF); with both held continuously, grant order is 0,1,0,1.
REQ-029 Backpressure: rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp0_result stay stable, req1_ready stays 0 throughout; release the hold -> IDLE on the next edge.
REQ-030 Reset mid-op: reset pulse during EXEC -> all rspn_valid=0 and alu_ctrl=000 immediately; no response is issued for that request.
REQ-031 Op pass-through: req1 slt with a=0xFFFFFFFD, b=1 -> alu_ctrl=101 during EXEC; with a reference ALU connected, rsp1_result=1.
